// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-set controller.
// State codes for RUN/HR/MIN/SEC double as the set_mode encoding.
package rtc_pkg;

    localparam int HR_W = 5;
    localparam int MS_W = 6;

    localparam logic [HR_W-1:0] MAX_HR  = 5'd23;
    localparam logic [MS_W-1:0] MAX_MIN = 6'd59;
    localparam logic [MS_W-1:0] MAX_SEC = 6'd59;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_SEC = 3'd3,
        COMMIT  = 3'd4
    } state_e;

    function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] v);
        return (v >= MAX_HR) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [MS_W-1:0] inc_ms(input logic [MS_W-1:0] v,
                                               input logic [MS_W-1:0] lim);
        return (v >= lim) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/rtc_btn_repeat.sv
// Rising-edge detect with hold auto-repeat for the increment button.
// kill drops the pulse of the current cycle and restarts the hold timer.
module rtc_btn_repeat #(
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic kill,
    output logic inc_pulse
);

    localparam int CW = $clog2(REPEAT_DLY + 1);
    localparam logic [CW-1:0] FIRE   = CW'(REPEAT_DLY - 1);
    localparam logic [CW-1:0] RELOAD = CW'(REPEAT_DLY - REPEAT_PER);

    logic          btn_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    always_comb begin
        inc_pulse = ~kill & btn & (~btn_q | (cnt == FIRE));
        cnt_d     = cnt + 1'b1;
        if (kill || !btn)
            cnt_d = '0;
        else if (!btn_q)
            cnt_d = CW'(1);
        else if (cnt == FIRE)
            // Re-arm so the next fire lands REPEAT_PER cycles later.
            cnt_d = RELOAD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q <= 1'b0;
            cnt   <= '0;
        end else begin
            btn_q <= btn;
            cnt   <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_set_ctrl.sv
// Time-set sequencer for the RTC counter: run gating, clear,
// hour/minute/second editing with blink, auto-repeat and timeout.
import rtc_pkg::*;

module rtc_set_ctrl #(
    parameter int BLINK_DIV  = 25000000,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000,
    parameter int TIMEOUT    = 500000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode_btn,
    input  logic            inc_btn,
    input  logic            clr_btn,
    input  logic [HR_W-1:0] cur_hr,
    input  logic [MS_W-1:0] cur_min,
    input  logic [MS_W-1:0] cur_sec,
    output logic            en,
    output logic            clr,
    output logic            load,
    output logic [HR_W-1:0] load_hr,
    output logic [MS_W-1:0] load_min,
    output logic [MS_W-1:0] load_sec,
    output logic [1:0]      set_mode,
    output logic [2:0]      blink_mask
);

    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);

    state_e          state, state_d;
    logic [HR_W-1:0] hr_d;
    logic [MS_W-1:0] min_d, sec_d;
    logic            phase, phase_d;
    logic [BW-1:0]   bcnt, bcnt_d;
    logic [TW-1:0]   idle, idle_d;
    logic            en_d, load_d;
    logic [1:0]      mode_d;
    logic [2:0]      mask_d;
    logic            in_set, set_d;
    logic            kill, inc_pulse;

    assign kill = mode_btn | clr_btn;

    rtc_btn_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_rep (
        .clk       (clk),
        .rst       (rst),
        .btn       (inc_btn),
        .kill      (kill),
        .inc_pulse (inc_pulse)
    );

    always_comb begin
        state_d = state;
        hr_d    = load_hr;
        min_d   = load_min;
        sec_d   = load_sec;
        phase_d = phase;
        bcnt_d  = bcnt;
        idle_d  = idle;
        in_set  = state inside {SET_HR, SET_MIN, SET_SEC};

        unique case (state)
            RUN: begin
                if (mode_btn) begin
                    hr_d    = cur_hr;
                    min_d   = cur_min;
                    sec_d   = cur_sec;
                    state_d = SET_HR;
                end
            end
            SET_HR: begin
                if (mode_btn)       state_d = SET_MIN;
                else if (inc_pulse) hr_d = inc_hr(load_hr);
            end
            SET_MIN: begin
                if (mode_btn)       state_d = SET_SEC;
                else if (inc_pulse) min_d = inc_ms(load_min, MAX_MIN);
            end
            SET_SEC: begin
                if (mode_btn)       state_d = COMMIT;
                else if (inc_pulse) sec_d = inc_ms(load_sec, MAX_SEC);
            end
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase

        // Abandon the edit; the RTC keeps counting from its old value.
        if (in_set && state_d == state && !inc_pulse && idle == IDLE_LAST)
            state_d = RUN;

        if (clr_btn) begin
            state_d = RUN;
            hr_d    = '0;
            min_d   = '0;
            sec_d   = '0;
        end

        set_d = state_d inside {SET_HR, SET_MIN, SET_SEC};

        if (!set_d || state_d != state || inc_pulse) begin
            idle_d  = '0;
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else begin
            idle_d = idle + 1'b1;
            if (bcnt == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase;
            end else begin
                bcnt_d = bcnt + 1'b1;
            end
        end

        en_d   = (state_d == RUN) & ~clr_btn;
        load_d = (state_d == COMMIT);
        mode_d = (state_d == COMMIT) ? 2'd0 : state_d[1:0];

        mask_d = 3'b000;
        unique case (state_d)
            SET_HR:  mask_d = {phase_d, 2'b00};
            SET_MIN: mask_d = {1'b0, phase_d, 1'b0};
            SET_SEC: mask_d = {2'b00, phase_d};
            default: mask_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            load_hr    <= '0;
            load_min   <= '0;
            load_sec   <= '0;
            phase      <= 1'b0;
            bcnt       <= '0;
            idle       <= '0;
            en         <= 1'b0;
            clr        <= 1'b0;
            load       <= 1'b0;
            set_mode   <= 2'd0;
            blink_mask <= 3'b000;
        end else begin
            state      <= state_d;
            load_hr    <= hr_d;
            load_min   <= min_d;
            load_sec   <= sec_d;
            phase      <= phase_d;
            bcnt       <= bcnt_d;
            idle       <= idle_d;
            en         <= en_d;
            clr        <= clr_btn;
            load       <= load_d;
            set_mode   <= mode_d;
            blink_mask <= mask_d;
        end
    end

endmodule
